// File: rtl/tkip_pkg.sv
// Shared types and helpers for the TKIP Phase I key mixer.
package tkip_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACC} state_t;

   localparam int unsigned NUM_ROUNDS = 8;
   localparam int unsigned NUM_STEPS  = 5;

   function automatic logic [15:0] mk16(input logic [7:0] h, input logic [7:0] l);
      return {h, l};
   endfunction

   // Byte pair {TK[base+j+1], TK[base+j]}; steps 0 and 4 both start at TK0.
   function automatic logic [15:0] tk_pair(input logic [127:0] tk,
                                           input logic [2:0]   step,
                                           input logic [2:0]   round);
      logic [3:0] base;
      logic [3:0] base_hi;
      base    = (step == 3'd4) ? 4'd0 : {step[1:0], 2'b00};
      base    = base + {1'b0, round[0], 2'b00} / 4'd2;
      base_hi = base + 4'd1;
      return mk16(tk[{base_hi, 3'b000} +: 8], tk[{base, 3'b000} +: 8]);
   endfunction

endpackage

// File: rtl/tkip_phase1_step_mux.sv
// Selects the previous TTAK word and TK byte pair feeding the current step's lookup.
module tkip_phase1_step_mux
   import tkip_pkg::*;
(
   input  logic [2:0]   i_step,
   input  logic [2:0]   i_round,
   input  logic [127:0] i_tk,
   input  logic [79:0]  i_ttak,
   output logic [15:0]  o_prev,
   output logic [15:0]  o_key
);

   always_comb begin
      o_prev = i_ttak[79:64];
      case (i_step)
         3'd1:    o_prev = i_ttak[15:0];
         3'd2:    o_prev = i_ttak[31:16];
         3'd3:    o_prev = i_ttak[47:32];
         3'd4:    o_prev = i_ttak[63:48];
         default: o_prev = i_ttak[79:64];
      endcase
   end

   assign o_key = tk_pair(i_tk, i_step, i_round);

endmodule

// File: rtl/tkip_phase1_mixer.sv
// TKIP Phase I key mixing: 8 rounds x 5 steps of S-box lookups producing the 80-bit TTAK.
module tkip_phase1_mixer
   import tkip_pkg::*;
#(
   parameter int unsigned SBOX_LATENCY = 1
)
(
   input  logic         bbClk,
   input  logic         hardRstBbClk_n,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] temporalKey,
   input  logic [47:0]  transAddr,
   input  logic [31:0]  iv32,
   output logic [7:0]   sBoxAddressA,
   output logic [7:0]   sBoxAddressB,
   input  logic [15:0]  sBoxDataA,
   input  logic [15:0]  sBoxDataB,
   output logic         busy,
   output logic         ttakValid,
   output logic [79:0]  ttak
);

   localparam logic [1:0] LAST_HOLD  = 2'(SBOX_LATENCY - 1);
   localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS - 1);
   localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_round;
   logic [2:0]  r_step;
   logic [1:0]  r_hold;
   logic [79:0] r_acc;
   logic [79:0] r_ttak;
   logic        r_ttak_valid;

   logic [15:0] w_prev;
   logic [15:0] w_key;
   logic [15:0] w_v;
   logic [15:0] w_cur;
   logic [15:0] w_sum;
   logic        w_last_step;
   logic        w_last_round;
   logic        w_last_hold;
   logic        w_lookup;

   tkip_phase1_step_mux u_step_mux (
      .i_step  (r_step),
      .i_round (r_round),
      .i_tk    (temporalKey),
      .i_ttak  (r_acc),
      .o_prev  (w_prev),
      .o_key   (w_key)
   );

   assign w_v          = w_prev ^ w_key;
   assign w_lookup     = (r_state == ADDR) || (r_state == WAIT);
   assign w_last_step  = (r_step == LAST_STEP);
   assign w_last_round = (r_round == LAST_ROUND);
   assign w_last_hold  = (r_hold == LAST_HOLD);
   assign w_cur        = r_acc[{r_step, 4'b0000} +: 16];
   assign w_sum        = w_cur + (sBoxDataA ^ sBoxDataB) + (w_last_step ? {13'b0, r_round} : 16'h0000);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:       if (start) w_state_nxt = ADDR;
         ADDR, WAIT: w_state_nxt = w_last_hold ? ACC : WAIT;
         ACC:        w_state_nxt = (w_last_step && w_last_round) ? IDLE : ADDR;
         default:    w_state_nxt = IDLE;
      endcase
      if (abort) w_state_nxt = IDLE;
   end

   always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
      if (!hardRstBbClk_n) r_state <= IDLE;
      else                 r_state <= w_state_nxt;
   end

   always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
      if (!hardRstBbClk_n) begin
         r_round      <= '0;
         r_step       <= '0;
         r_hold       <= '0;
         r_acc        <= '0;
         r_ttak       <= '0;
         r_ttak_valid <= 1'b0;
      end else begin
         r_ttak_valid <= 1'b0;
         if (abort) begin
            r_round <= '0;
            r_step  <= '0;
            r_hold  <= '0;
         end else begin
            case (r_state)
               IDLE: if (start) begin
                  r_acc   <= {transAddr[47:32], transAddr[31:16], transAddr[15:0], iv32[31:16], iv32[15:0]};
                  r_round <= '0;
                  r_step  <= '0;
                  r_hold  <= '0;
               end
               ADDR, WAIT: r_hold <= r_hold + 2'd1;
               ACC: begin
                  r_hold                          <= '0;
                  r_acc[{r_step, 4'b0000} +: 16] <= w_sum;
                  if (w_last_step) begin
                     r_step  <= '0;
                     r_round <= r_round + 3'd1;
                     // Final step: TTAK4 is still being written, so capture it from the adder.
                     if (w_last_round) begin
                        r_ttak       <= {w_sum, r_acc[63:0]};
                        r_ttak_valid <= 1'b1;
                     end
                  end else begin
                     r_step <= r_step + 3'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sBoxAddressA = w_lookup ? w_v[7:0]  : 8'h00;
   assign sBoxAddressB = w_lookup ? w_v[15:8] : 8'h00;
   assign busy         = (r_state != IDLE);
   assign ttakValid    = r_ttak_valid;
   assign ttak         = r_ttak;

endmodule

// File: doc/tkip_phase1_mixer.md
Name: tkip_phase1_mixer

Overview:
- Initiator side of the TKIP S-box lookup interface: runs TKIP Phase I key mixing over 40 sequential S-box lookups.
- Computes the 80-bit TTAK from the temporal key TK, transmitter address TA and IV32.
- Drives the two 8-bit S-box addresses and consumes the registered 16-bit A/B table words returned by the shared TKIP S-box.
- Sits in the MAC TKIP path ahead of Phase II; one Phase I computation per IV32 change.

Parameters:
- SBOX_LATENCY, 1, cycles from address presentation to valid sBoxDataA/B; 1 or 2 supported.

Ports:
- bbClk  input  1  baseband clock
- hardRstBbClk_n  input  1  asynchronous active-low hardware reset
- start  input  1  one-cycle request; sampled only in IDLE
- abort  input  1  synchronous cancel; highest priority after reset
- temporalKey  input  128  TK; TKn = temporalKey[8n+7:8n]
- transAddr  input  48  TA; TAn = transAddr[8n+7:8n]
- iv32  input  32  TSC upper 32 bits
- sBoxAddressA  output  8  low-byte lookup index
- sBoxAddressB  output  8  high-byte lookup index
- sBoxDataA  input  16  table word for sBoxAddressA
- sBoxDataB  input  16  byte-swapped table word for sBoxAddressB
- busy  output  1  computation in progress
- ttakValid  output  1  one-cycle pulse; ttak is valid
- ttak  output  80  {TTAK4,TTAK3,TTAK2,TTAK1,TTAK0}, TTAK0 in [15:0]

Behaviour:
- Interface: one clock, bbClk. Reset is asynchronous, active-low, on hardRstBbClk_n.
- Reset values:
  - State is IDLE.
  - busy=0, ttakValid=0, ttak=80'h0.
  - sBoxAddressA/B=8'h00.
  - Round and step counters are 0.
- Mk16(h,l) = {h,l}.
- S(v) = sBoxDataA ^ sBoxDataB, with sBoxAddressA = v[7:0] and sBoxAddressB = v[15:8].
- All additions are mod 2^16.
- States:
  - IDLE: when start=1, load TTAK0=iv32[15:0], TTAK1=iv32[31:16], TTAK2=Mk16(TA1,TA0), TTAK3=Mk16(TA3,TA2), TTAK4=Mk16(TA5,TA4). Clear round i and step s. Go to ADDR. busy=1 from the next cycle.
  - ADDR: drive sBoxAddressA/B combinationally from v = prev ^ key, where j=2*(i&1).
    - s0: prev=TTAK4, key=Mk16(TK1+j,TK0+j)
    - s1: prev=TTAK0, key=Mk16(TK5+j,TK4+j)
    - s2: prev=TTAK1, key=Mk16(TK9+j,TK8+j)
    - s3: prev=TTAK2, key=Mk16(TK13+j,TK12+j)
    - s4: prev=TTAK3, key=Mk16(TK1+j,TK0+j)
    - Addresses are held stable for SBOX_LATENCY cycles (WAIT); the last held cycle moves to ACC.
  - ACC: TTAKs += S(v). For s4 also add i (zero-extended).
    - If s<4: s++, go to ADDR.
    - If s=4 and i<7: s=0, i++, go to ADDR.
    - If s=4 and i=7: register ttak, pulse ttakValid, clear busy, go to IDLE.
- Latency with SBOX_LATENCY=L:
  - Each step takes L+1 cycles; 40 steps in total.
  - start sampled at edge N → ttakValid high in the cycle after edge N+40(L+1).
  - L=1 gives 80 cycles.
  - busy is high in the cycles after edges N through N+40(L+1)-1.
- Addresses outside ADDR/WAIT are 8'h00.
- ttak holds its last result until the next completion.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - start and abort in the same IDLE cycle: abort wins; stay IDLE.
  - abort while busy: next edge goes to IDLE, busy=0, no ttakValid, ttak keeps its previous value.
  - temporalKey/transAddr/iv32 are sampled only at start for TA/IV. TK must be held stable while busy; it is read every step.
  - Asynchronous reset mid-computation returns everything to reset values immediately.
  - The ttakValid pulse coincides with busy falling. A start in that same cycle is accepted, giving back-to-back operation.

Decomposition:
- Package tkip_pkg holds:
  - the state enum (IDLE, ADDR, WAIT, ACC);
  - localparams NUM_ROUNDS=8 and NUM_STEPS=5;
  - a Mk16 function;
  - a TK byte-pair selector function taking (tk, step, round).
- One natural sub-module, tkip_phase1_step_mux: combinational selection of prev/key for the current step. The FSM, counters and accumulators stay in the top module.

Test Plan:
- Reset: assert hardRstBbClk_n=0 mid-computation → busy=0, ttakValid=0, ttak=0, addresses 00 within the same cycle.
- Golden vector: TK=00 01 .. 0f, TA=10 22 33 44 55 66, IV32=0, SBOX_LATENCY=1, connected to sBoxTKIP → ttakValid exactly 80 cycles after the start edge. ttak matches the tkipPhase1 C model bit-exact; 1000 random TK/TA/IV32 also match.
- Latency variants: SBOX_LATENCY=2 with a one-flop delay model on the S-box data → ttakValid at +120 cycles with the same ttak. Addresses are stable across each WAIT cycle.
- First lookup: IV32=0x0000ABCD, TA5TA4=0x1234, TK1TK0=0x5678 → first ADDR cycle drives sBoxAddressB=0x12^0x56=0x44, sBoxAddressA=0x34^0x78=0x4C.
- Control: start pulses while busy are ignored (exactly one ttakValid). abort at cycle 37 → no ttakValid and ttak unchanged. start in the ttakValid cycle → second result at +80.
- Wrap-around: constrain the S-box model to return 16'hFFFF → all additions wrap mod 2^16; the round increment on TTAK4 is verified against the model.
